ecdsa_arg_sequencer: RTL and testbench

// Sequences one EC-core operation from CSR programming: reads the input address table from the shared 1024-bit

---
 rtl/ecdsa_pkg.sv | 20 ++
 rtl/ecdsa_tbl_slot_mux.sv | 32 +++
 rtl/ecdsa_arg_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ecdsa_arg_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA argument sequencer: sequencer states, table geometry and op codes.
package ecdsa_pkg;

    localparam int unsigned MAX_ARGS  = 32;
    localparam int unsigned SLOT_W    = 32;
    localparam int unsigned PTR_W     = 16;
    localparam logic [3:0]  OP_EC_ADD = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TBL_I,
        S_ARG_RD,
        S_ARG_LD,
        S_START,
        S_WAIT,
        S_TBL_O,
        S_RES_WR
    } seq_state_t;

endpackage

// File: rtl/ecdsa_tbl_slot_mux.sv
// Picks 32-bit slot k from a latched address-table word and turns its 16-bit byte pointer into a BRAM word address.
module ecdsa_tbl_slot_mux
    import ecdsa_pkg::*;
#(
    parameter int unsigned DW     = 1024,
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned IW     = 5
) (
    input  logic [DW-1:0]     i_tbl,
    input  logic [IW-1:0]     i_idx,
    output logic [MEM_AW-1:0] o_waddr
);

    logic [SLOT_W-1:0] w_slot;
    logic [31:0]       w_byte;
    logic              w_unused;

    // Slot 0 sits in the most significant 32 bits of the table word.
    always_comb begin
        w_slot = '0;
        for (int unsigned s = 0; s < DW / SLOT_W; s++) begin
            if (i_idx == IW'(s)) begin
                w_slot = i_tbl[DW-1-SLOT_W*s -: SLOT_W];
            end
        end
    end

    assign w_byte   = {{(32 - PTR_W){1'b0}}, w_slot[PTR_W-1:0]};
    assign o_waddr  = w_byte[MEM_AW+6:7];
    assign w_unused = ^{w_slot[SLOT_W-1:PTR_W], w_byte[6:0], w_byte[31:MEM_AW+7]};

endmodule

// File: rtl/ecdsa_arg_sequencer.sv
// Runs one EC-core operation: fetch input table and operands from BRAM, start the core, write results back.
module ecdsa_arg_sequencer #(
    parameter int unsigned DW       = 1024,
    parameter int unsigned MEM_AW   = 10,
    parameter int unsigned MAX_ARGS = 32,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        csr_start,
    input  logic [3:0]                  csr_op,
    input  logic                        csr_clear,
    input  logic [31:0]                 csr_tbl_i,
    input  logic [31:0]                 csr_argc_i,
    input  logic [31:0]                 csr_tbl_o,
    input  logic [31:0]                 csr_argc_o,
    output logic                        stat_busy,
    output logic                        stat_done,
    output logic                        stat_err,
    output logic [MEM_AW-1:0]           mem_addr,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [DW-1:0]               mem_din,
    input  logic [DW-1:0]               mem_dout,
    output logic                        core_ld_valid,
    output logic [$clog2(MAX_ARGS)-1:0] core_ld_idx,
    output logic [DW-1:0]               core_ld_data,
    output logic                        core_start,
    output logic [3:0]                  core_op,
    input  logic                        core_done,
    output logic [$clog2(MAX_ARGS)-1:0] core_res_idx,
    input  logic [DW-1:0]               core_res_data
);
    import ecdsa_pkg::*;

    localparam int unsigned IW = $clog2(MAX_ARGS);
    localparam int unsigned CW = $clog2(MAX_ARGS + 1);
    localparam int unsigned LW = $clog2(RD_LAT + 1);

    seq_state_t        r_state, w_next;
    logic [3:0]        r_op;
    logic [MEM_AW-1:0] r_tbl_i_wa, r_tbl_o_wa;
    logic [CW-1:0]     r_argc_i, r_argc_o, r_k, r_j;
    logic [LW-1:0]     r_lat;
    logic [DW-1:0]     r_tbl;
    logic              r_done, r_err;

    logic              w_bad_argc, w_tbl_last, w_rd_last, w_k_last, w_j_last;
    logic [IW-1:0]     w_sel;
    logic [MEM_AW-1:0] w_ptr_wa;
    logic              w_unused;

    assign w_bad_argc = (csr_argc_i == '0) || (csr_argc_i > MAX_ARGS) ||
                        (csr_argc_o == '0) || (csr_argc_o > MAX_ARGS);
    assign w_tbl_last = (r_lat == LW'(RD_LAT));
    assign w_rd_last  = (r_lat == LW'(RD_LAT - 1));
    assign w_k_last   = ((r_k + CW'(1)) == r_argc_i);
    assign w_j_last   = ((r_j + CW'(1)) == r_argc_o);
    assign w_sel      = (r_state == S_RES_WR) ? r_j[IW-1:0] : r_k[IW-1:0];
    assign w_unused   = ^{csr_tbl_i, csr_tbl_o, csr_argc_i, csr_argc_o};

    ecdsa_tbl_slot_mux #(
        .DW     (DW),
        .MEM_AW (MEM_AW),
        .IW     (IW)
    ) u_slot_mux (
        .i_tbl   (r_tbl),
        .i_idx   (w_sel),
        .o_waddr (w_ptr_wa)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_tbl_i_wa <= '0;
            r_tbl_o_wa <= '0;
            r_argc_i   <= '0;
            r_argc_o   <= '0;
            r_k        <= '0;
            r_j        <= '0;
            r_lat      <= '0;
            r_tbl      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_k   <= '0;
                    r_j   <= '0;
                    r_lat <= '0;
                end
                S_TBL_I, S_TBL_O: begin
                    if (w_tbl_last) begin
                        r_tbl <= mem_dout;
                        r_lat <= '0;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_ARG_RD: r_lat <= w_rd_last ? '0 : r_lat + LW'(1);
                S_ARG_LD: r_k   <= r_k + CW'(1);
                S_RES_WR: r_j   <= r_j + CW'(1);
                default: ;
            endcase

            // A start in IDLE takes priority over a simultaneous clear; it resets the flags itself.
            if (r_state == S_IDLE) begin
                if (csr_start) begin
                    r_op       <= csr_op;
                    r_tbl_i_wa <= csr_tbl_i[MEM_AW+6:7];
                    r_tbl_o_wa <= csr_tbl_o[MEM_AW+6:7];
                    r_argc_i   <= csr_argc_i[CW-1:0];
                    r_argc_o   <= csr_argc_o[CW-1:0];
                    r_done     <= w_bad_argc;
                    r_err      <= w_bad_argc;
                end else if (csr_clear) begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
            end else begin
                if (csr_start) begin
                    r_err <= 1'b1;
                end
                if ((r_state == S_RES_WR) && w_j_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_din       = '0;
        core_ld_valid = 1'b0;
        core_ld_idx   = '0;
        core_ld_data  = '0;
        core_start    = 1'b0;
        core_res_idx  = '0;
        case (r_state)
            S_IDLE: begin
                if (csr_start && !w_bad_argc) w_next = S_TBL_I;
            end
            S_TBL_I: begin
                if (r_lat == '0) begin
                    mem_en   = 1'b1;
                    mem_addr = r_tbl_i_wa;
                end
                if (w_tbl_last) w_next = S_ARG_RD;
            end
            S_ARG_RD: begin
                if (r_lat == '0) begin
                    mem_en   = 1'b1;
                    mem_addr = w_ptr_wa;
                end
                if (w_rd_last) w_next = S_ARG_LD;
            end
            S_ARG_LD: begin
                core_ld_valid = 1'b1;
                core_ld_idx   = r_k[IW-1:0];
                core_ld_data  = mem_dout;
                w_next        = w_k_last ? S_START : S_ARG_RD;
            end
            S_START: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) w_next = S_TBL_O;
            end
            S_TBL_O: begin
                if (r_lat == '0) begin
                    mem_en   = 1'b1;
                    mem_addr = r_tbl_o_wa;
                end
                if (w_tbl_last) w_next = S_RES_WR;
            end
            S_RES_WR: begin
                mem_en       = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = w_ptr_wa;
                mem_din      = core_res_data;
                core_res_idx = r_j[IW-1:0];
                if (w_j_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign stat_busy = (r_state != S_IDLE);
    assign stat_done = r_done;
    assign stat_err  = r_err;
    assign core_op   = r_op;

endmodule

// File: tb/tb_ecdsa_arg_sequencer.sv
// Scoreboard bench for ecdsa_arg_sequencer with behavioural BRAM and EC-core models.
module tb_ecdsa_arg_sequencer;

    localparam int unsigned DW = 1024;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          csr_start = 1'b0, csr_clear = 1'b0;
    logic [3:0]    csr_op = 4'd0;
    logic [31:0]   csr_tbl_i = '0, csr_argc_i = '0, csr_tbl_o = '0, csr_argc_o = '0;
    logic          stat_busy, stat_done, stat_err;
    logic [AW-1:0] mem_addr;
    logic          mem_en, mem_we;
    logic [DW-1:0] mem_din, mem_dout, core_ld_data, core_res_data;
    logic          core_ld_valid, core_start, core_done;
    logic [4:0]    core_ld_idx, core_res_idx;
    logic [3:0]    core_op;

    ecdsa_arg_sequencer #(
        .DW       (DW),
        .MEM_AW   (AW),
        .MAX_ARGS (32),
        .RD_LAT   (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .csr_start     (csr_start),
        .csr_op        (csr_op),
        .csr_clear     (csr_clear),
        .csr_tbl_i     (csr_tbl_i),
        .csr_argc_i    (csr_argc_i),
        .csr_tbl_o     (csr_tbl_o),
        .csr_argc_o    (csr_argc_o),
        .stat_busy     (stat_busy),
        .stat_done     (stat_done),
        .stat_err      (stat_err),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .core_ld_valid (core_ld_valid),
        .core_ld_idx   (core_ld_idx),
        .core_ld_data  (core_ld_data),
        .core_start    (core_start),
        .core_op       (core_op),
        .core_done     (core_done),
        .core_res_idx  (core_res_idx),
        .core_res_data (core_res_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] opnd(input int unsigned w);
        return {32{32'hA500_0000 | w}};
    endfunction

    function automatic logic [DW-1:0] res_pat(input logic [4:0] j);
        return {32{32'hC0DE_0000 | 32'(j)}};
    endfunction

    // BRAM: registered read, writes are only observed by the scoreboard
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (mem_en && !mem_we) mem_dout <= mem[mem_addr];

    // EC core: done pulse core_delay cycles after start, reset with the sequencer
    int unsigned core_delay = 3;
    int unsigned c_cnt;
    logic        c_busy;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_done <= 1'b0;
            c_busy    <= 1'b0;
            c_cnt     <= 0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                c_busy <= 1'b1;
                c_cnt  <= core_delay;
            end else if (c_busy) begin
                if (c_cnt == 0) begin
                    core_done <= 1'b1;
                    c_busy    <= 1'b0;
                end else begin
                    c_cnt <= c_cnt - 1;
                end
            end
        end
    end
    assign core_res_data = res_pat(core_res_idx);

    typedef struct packed { logic [4:0] idx; logic [DW-1:0] data; } ld_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

    logic [AW-1:0] rd_q[$];
    ld_t           ld_q[$];
    wr_t           wr_q[$];
    int            n_cmp = 0, n_err = 0;
    int            exp_starts = 0, n_starts = 0, n_writes = 0;
    int            cyc = 0, last_we_cyc = 0;
    int            wait_traffic = 0, busy_drop = 0;
    logic          in_wait = 1'b0;
    logic [3:0]    exp_op = 4'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got ..%016h expected ..%016h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event with value %0h, expected none", name, act);
    endtask

    logic [AW-1:0] e_rd;
    ld_t           e_ld;
    wr_t           e_wr;

    // Monitor: pops expectations as the DUT presents reads, loads, starts and writes
    always @(negedge clk) begin
        if (resetn) begin
            if (in_wait) begin
                if (mem_en) wait_traffic++;
                if (!stat_busy) busy_drop++;
                if (core_done) in_wait = 1'b0;
            end
            if (mem_en && !mem_we) begin
                if (rd_q.size() == 0) unexpected("read", 64'(mem_addr));
                else begin
                    e_rd = rd_q.pop_front();
                    chk("read_addr", 64'(mem_addr), 64'(e_rd));
                end
            end
            if (mem_en && mem_we) begin
                n_writes++;
                last_we_cyc = cyc;
                if (wr_q.size() == 0) unexpected("write", 64'(mem_addr));
                else begin
                    e_wr = wr_q.pop_front();
                    chk("write_addr", 64'(mem_addr), 64'(e_wr.addr));
                    chk_w("write_data", mem_din, e_wr.data);
                end
            end
            if (core_ld_valid) begin
                if (ld_q.size() == 0) unexpected("load", 64'(core_ld_idx));
                else begin
                    e_ld = ld_q.pop_front();
                    chk("load_idx", 64'(core_ld_idx), 64'(e_ld.idx));
                    chk_w("load_data", core_ld_data, e_ld.data);
                end
            end
            if (core_start) begin
                n_starts++;
                in_wait = 1'b1;
                if (n_starts > exp_starts) unexpected("core_start", 64'(n_starts));
                chk("core_op", 64'(core_op), 64'(exp_op));
            end
        end
    end

    // Tables at bytes 0x000 / 0x400; operand pointers 0x080.., result pointers 0x480..
    task automatic build(input bit hi_ff);
        logic [DW-1:0] ti, to;
        logic [15:0]   hi;
        hi = hi_ff ? 16'hFFFF : 16'h0000;
        ti = {32{32'hDEAD_BEEF}};
        to = ti;
        for (int unsigned k = 0; k < 6; k++) begin
            ti[DW-1-32*k -: 32] = {hi, 16'(16'h0080 * (k + 1))};
            mem[k+1] = opnd(k + 1);
        end
        for (int unsigned j = 0; j < 3; j++) to[DW-1-32*j -: 32] = {hi, 16'(16'h0480 + 16'h0080 * j)};
        mem[0] = ti;
        mem[8] = to;
        rd_q.push_back(AW'(0));
        for (int unsigned k = 0; k < 6; k++) begin
            rd_q.push_back(AW'(k + 1));
            ld_q.push_back('{idx: 5'(k), data: opnd(k + 1)});
        end
        rd_q.push_back(AW'(8));
        for (int unsigned j = 0; j < 3; j++) wr_q.push_back('{addr: AW'(9 + j), data: res_pat(5'(j))});
        exp_starts++;
    endtask

    task automatic pulse_start(input logic [31:0] ti, ai, to, ao, input logic clr);
        @(negedge clk);
        csr_tbl_i  = ti;
        csr_argc_i = ai;
        csr_tbl_o  = to;
        csr_argc_o = ao;
        csr_op     = 4'd1;
        csr_start  = 1'b1;
        csr_clear  = clr;
        @(negedge clk);
        csr_start  = 1'b0;
        csr_clear  = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        csr_clear = 1'b1;
        @(negedge clk);
        csr_clear = 1'b0;
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned n = 0;
        while (!stat_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!stat_done) unexpected("done_timeout", 64'(n));
        else chk("done_after_last_write", 64'(cyc - last_we_cyc), 64'd1);
    endtask

    task automatic check_end(input string name, input logic exp_err);
        chk({name, "_done"}, 64'(stat_done), 64'd1);
        chk({name, "_err"}, 64'(stat_err), 64'(exp_err));
        chk({name, "_busy"}, 64'(stat_busy), 64'd0);
        chk({name, "_pending"}, 64'(rd_q.size() + ld_q.size() + wr_q.size()), 64'd0);
        chk({name, "_starts"}, 64'(n_starts), 64'(exp_starts));
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, 64'({stat_busy, stat_done, stat_err, mem_en, mem_we, core_ld_valid, core_start,
                       mem_addr, core_ld_idx, core_op, core_res_idx, |mem_din, |core_ld_data}), 64'd0);
    endtask

    initial begin
        int w0;
        int unsigned n;
        #2 resetn = 1'b0;
        #1 check_outputs_zero("reset_outputs");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Normal EC add
        build(1'b0);
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        wait_done(200);
        check_end("ec_add", 1'b0);

        // Bad argc: flags the cycle after start, no traffic
        pulse_start(32'h000, 32'd0, 32'h400, 32'd3, 1'b0);
        chk("argc0_done", 64'(stat_done), 64'd1);
        chk("argc0_err", 64'(stat_err), 64'd1);
        chk("argc0_busy", 64'(stat_busy), 64'd0);
        pulse_clear();
        chk("clear_flags", 64'({stat_done, stat_err}), 64'd0);
        pulse_start(32'h000, 32'd33, 32'h400, 32'd3, 1'b1);
        chk("argc33_flags", 64'({stat_done, stat_err, stat_busy}), 64'b110);
        pulse_clear();
        chk("clear_flags2", 64'({stat_done, stat_err}), 64'd0);
        repeat (3) @(negedge clk);
        chk("bad_argc_no_start", 64'(n_starts), 64'(exp_starts));

        // Start while waiting on core: err set, sequence unaffected
        core_delay = 20;
        build(1'b0);
        w0 = n_writes;
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        n = 0;
        while (!core_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) unexpected("core_start_timeout", 64'(n));
        pulse_start(32'h000, 32'd0, 32'h000, 32'd0, 1'b0);
        wait_done(200);
        check_end("start_in_wait", 1'b1);
        chk("start_in_wait_writes", 64'(n_writes - w0), 64'd3);

        // Upper pointer bits set: same addresses
        core_delay = 3;
        build(1'b1);
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        wait_done(200);
        check_end("hi_ffff", 1'b0);

        // Slow core
        core_delay = 500;
        wait_traffic = 0;
        busy_drop = 0;
        build(1'b0);
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        wait_done(800);
        check_end("slow_core", 1'b0);
        chk("slow_wait_traffic", 64'(wait_traffic), 64'd0);
        chk("slow_busy_drop", 64'(busy_drop), 64'd0);

        // Reset during an operand load, then a clean rerun
        core_delay = 3;
        build(1'b0);
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        n = 0;
        while (!(core_ld_valid && core_ld_idx == 5'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!core_ld_valid) unexpected("ld_wait_timeout", 64'(n));
        #1 resetn = 1'b0;
        #1 check_outputs_zero("midrun_reset_outputs");
        rd_q.delete();
        ld_q.delete();
        wr_q.delete();
        exp_starts = n_starts;
        in_wait = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        build(1'b0);
        pulse_start(32'h000, 32'd6, 32'h400, 32'd3, 1'b0);
        wait_done(200);
        check_end("after_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
